aes_core_arbiter: RTL

//  Shares one AES-128 encryption core between NUM_REQ requesters. Round-robin

---
 rtl/aes_core_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/aes_core_arbiter.sv
// -----------------------------------------------------------------------------
// aes_core_arbiter
//
// Shares a single AES-128 encryption core between NUM_REQ requesters.
// A round-robin arbiter picks one pending request and latches its
// plaintext, key and requester index. It then pulses core_start for one
// cycle and waits for core_done, or gives up after TIMEOUT cycles. Finally
// it holds the ciphertext, tagged with the requester index, until the
// consumer takes it.
//
// Ports
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   req_valid      per-requester request pending
//   req_ready      one-hot accept strobe, only asserted in IDLE
//   req_data       plaintexts, requester i at [128*i +: 128]
//   req_key        keys, requester i at [128*i +: 128]
//   rsp_valid      response available (held until rsp_ready)
//   rsp_ready      response consumer ready
//   rsp_id         index of the requester being answered
//   rsp_data       ciphertext (0 on timeout)
//   rsp_err        1 = core timed out
//   core_start     one-cycle start pulse to the core
//   core_data      latched plaintext to the core
//   core_key       latched key to the core
//   core_done      core completion (level or pulse), only looked at in WAIT
//   core_dataout   core ciphertext, valid while core_done=1
//   busy           1 whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module aes_core_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*128-1:0] req_data,
   input  logic [NUM_REQ*128-1:0] req_key,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [127:0]           rsp_data,
   output logic                   rsp_err,
   output logic                   core_start,
   output logic [127:0]           core_data,
   output logic [127:0]           core_key,
   input  logic                   core_done,
   input  logic [127:0]           core_dataout,
   output logic                   busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state_reg;
   logic [ID_W-1:0]  ptr_reg;
   logic [ID_W-1:0]  id_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [127:0]     data_reg;
   logic [127:0]     key_reg;
   logic [127:0]     rsp_data_reg;
   logic             rsp_err_reg;
   logic             rsp_valid_reg;
   logic             core_start_reg;
   logic             busy_reg;

   // Round-robin search state. cand carries one extra bit so that ptr+off
   // can be folded back below NUM_REQ without overflowing.
   logic             found;
   logic [ID_W-1:0]  winner;
   logic [ID_W:0]    cand;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = {1'b0, ptr_reg} + (ID_W+1)'(off);
         if (cand >= (ID_W+1)'(NUM_REQ))
            cand = cand - (ID_W+1)'(NUM_REQ);
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[ID_W-1:0];
         end
      end
   end

   // The accept strobe is combinational so the requester sees it in the
   // same cycle that the request is taken.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = (state_reg == IDLE) && found && (winner == ID_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         ptr_reg        <= '0;
         id_reg         <= '0;
         cnt_reg        <= '0;
         data_reg       <= '0;
         key_reg        <= '0;
         rsp_data_reg   <= '0;
         rsp_err_reg    <= 1'b0;
         rsp_valid_reg  <= 1'b0;
         core_start_reg <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         core_start_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // found in IDLE means req_ready is up, so this edge is the handshake.
               if (found) begin
                  data_reg       <= req_data[128*int'(winner) +: 128];
                  key_reg        <= req_key[128*int'(winner) +: 128];
                  id_reg         <= winner;
                  core_start_reg <= 1'b1;
                  busy_reg       <= 1'b1;
                  state_reg      <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_reg   <= '0;
               state_reg <= WAIT;
            end
            WAIT: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               // A completion in the last allowed cycle still counts as success.
               if (core_done) begin
                  rsp_data_reg  <= core_dataout;
                  rsp_err_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                  rsp_data_reg  <= '0;
                  rsp_err_reg   <= 1'b1;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  ptr_reg       <= (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_reg;
   assign rsp_id     = id_reg;
   assign rsp_data   = rsp_data_reg;
   assign rsp_err    = rsp_err_reg;
   assign core_start = core_start_reg;
   assign core_data  = data_reg;
   assign core_key   = key_reg;
   assign busy       = busy_reg;

endmodule
